// File: rtl/dma_channel_scheduler_pkg.sv
// rtl/dma_channel_scheduler_pkg.sv - shared defaults, index widths and FSM encoding for the DMA scheduler
package dma_sched_pkg;

    localparam int DEF_NUM_CH     = 3;
    localparam int DEF_ADDR_WIDTH = 22;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 12;
    localparam int DEF_BURST_LEN  = 8;

    localparam int CH_IDX_W  = $clog2(DEF_NUM_CH);
    localparam int BUF_IDX_W = $clog2(DEF_BURST_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_RD,
        ST_WR,
        ST_DONE
    } sched_state_t;

endpackage

// File: rtl/dma_channel_scheduler_if.sv
// rtl/dma_channel_scheduler_if.sv - memory controller DMA port (req/rw/addr/wdata/ack/rdata)
interface dma_channel_scheduler_if #(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 32
) ();

    logic                  mem_req;
    logic                  mem_rw;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_rw, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_rw, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/dma_channel_scheduler_buffer.sv
// rtl/dma_channel_scheduler_buffer.sv - burst staging FIFO with head and head+1 lookahead
module dma_burst_buffer #(
    parameter  int DEPTH      = 8,
    parameter  int DATA_WIDTH = 32,
    localparam int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [DATA_WIDTH-1:0] head_next,
    output logic                  empty,
    output logic                  full
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]      wr_ptr;
    logic [IDX_W-1:0]      rd_ptr;
    logic [IDX_W-1:0]      rd_ptr_nx;
    logic [IDX_W:0]        count;

    // head_next lets the write phase load the following word on the same ack edge as the pop
    assign rd_ptr_nx = rd_ptr + 1'b1;
    assign head      = mem_q[rd_ptr];
    assign head_next = mem_q[rd_ptr_nx];
    assign empty     = (count == '0);
    assign full      = (count == (IDX_W+1)'(DEPTH));

    // storage and pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr] <= push_data;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nx;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // the scheduler never reads more than DEPTH words before draining them
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && full && !pop));
            assert (!(pop && empty));
        end
    end

endmodule

// File: rtl/dma_channel_scheduler.sv
// rtl/dma_channel_scheduler.sv - round-robin multi-channel DMA copy engine; DMA_SCHED_PERF_EN adds perf_words/perf_stall
module dma_channel_scheduler
    import dma_sched_pkg::*;
#(
    parameter  int NUM_CH     = DEF_NUM_CH,
    parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter  int BURST_LEN  = DEF_BURST_LEN,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int BUF_W      = $clog2(BURST_LEN)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [NUM_CH-1:0]           ch_desc_valid,
    output logic [NUM_CH-1:0]           ch_desc_ready,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_src_addr,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_dst_addr,
    input  logic [NUM_CH*LEN_WIDTH-1:0]  ch_len,
    output logic [NUM_CH-1:0]           ch_done,
    dma_channel_scheduler_if.master     mem,
    output logic                        busy,
    output logic [CH_W-1:0]             active_ch
`ifdef DMA_SCHED_PERF_EN
    ,
    output logic [31:0]                 perf_words,
    output logic [31:0]                 perf_stall
`endif
);

    sched_state_t          state, state_d;
    logic [NUM_CH-1:0]     pending;
    logic [ADDR_WIDTH-1:0] src_q [NUM_CH];
    logic [ADDR_WIDTH-1:0] dst_q [NUM_CH];
    logic [LEN_WIDTH-1:0]  rem_q [NUM_CH];

    // rr_next holds rr_ptr+1 so that a cleared pointer starts the first search at channel 0
    logic [CH_W-1:0]       grant, rr_next, arb_ch, scan_idx;
    logic                  arb_found;
    logic [BUF_W:0]        burst_n, op_cnt, arb_n;

    logic                  req_q, rw_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  ack, last_op, push, pop;
    logic                  buf_empty, buf_full;
    logic [DATA_WIDTH-1:0] buf_head, buf_head_next;

    assign ack     = req_q && mem.mem_ack;
    assign last_op = (op_cnt == burst_n - 1'b1);
    assign push    = (state == ST_RD) && ack && !buf_full;
    assign pop     = (state == ST_WR) && ack;

    dma_burst_buffer #(
        .DEPTH      (BURST_LEN),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (mem.mem_rdata),
        .pop       (pop),
        .head      (buf_head),
        .head_next (buf_head_next),
        .empty     (buf_empty),
        .full      (buf_full)
    );

    // round-robin search from rr_next and burst size of the winner
    always_comb begin
        arb_found = 1'b0;
        arb_ch    = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            scan_idx = CH_W'((int'(rr_next) + k) % NUM_CH);
            if (!arb_found && pending[scan_idx]) begin
                arb_found = 1'b1;
                arb_ch    = scan_idx;
            end
        end
        arb_n = (rem_q[arb_ch] >= LEN_WIDTH'(BURST_LEN)) ? (BUF_W+1)'(BURST_LEN)
                                                         : rem_q[arb_ch][BUF_W:0];
    end

    // next-state decode
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (enable && |pending) state_d = ST_ARB;
            ST_ARB: begin
                if (!enable || !arb_found)      state_d = ST_IDLE;
                else if (rem_q[arb_ch] == '0)   state_d = ST_DONE;
                else                            state_d = ST_RD;
            end
            ST_RD:   if (ack && last_op) state_d = ST_WR;
            ST_WR:   if (ack && last_op) state_d = (rem_q[grant] == LEN_WIDTH'(1)) ? ST_DONE : ST_ARB;
            ST_DONE: state_d = ST_ARB;
            default: state_d = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    // descriptor latching, burst bookkeeping and registered memory port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            grant   <= '0;
            rr_next <= '0;
            burst_n <= '0;
            op_cnt  <= '0;
            req_q   <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                src_q[i] <= '0;
                dst_q[i] <= '0;
                rem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_desc_valid[i] && !pending[i]) begin
                    pending[i] <= 1'b1;
                    src_q[i]   <= ch_src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    dst_q[i]   <= ch_dst_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    rem_q[i]   <= ch_len[i*LEN_WIDTH +: LEN_WIDTH];
                end
            end
            case (state)
                ST_ARB: begin
                    if (state_d != ST_IDLE) begin
                        grant   <= arb_ch;
                        rr_next <= (arb_ch == CH_W'(NUM_CH-1)) ? '0 : arb_ch + 1'b1;
                        burst_n <= arb_n;
                        op_cnt  <= '0;
                    end
                    if (state_d == ST_RD) begin
                        req_q  <= 1'b1;
                        rw_q   <= 1'b0;
                        addr_q <= src_q[arb_ch];
                    end
                end
                ST_RD: begin
                    if (ack) begin
                        src_q[grant] <= src_q[grant] + 1'b1;
                        if (last_op) begin
                            // a single-word burst has nothing buffered yet; forward the read data
                            op_cnt  <= '0;
                            rw_q    <= 1'b1;
                            addr_q  <= dst_q[grant];
                            wdata_q <= buf_empty ? mem.mem_rdata : buf_head;
                        end else begin
                            op_cnt <= op_cnt + 1'b1;
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    if (ack) begin
                        dst_q[grant] <= dst_q[grant] + 1'b1;
                        rem_q[grant] <= rem_q[grant] - 1'b1;
                        if (last_op) begin
                            req_q <= 1'b0;
                            rw_q  <= 1'b0;
                        end else begin
                            op_cnt  <= op_cnt + 1'b1;
                            addr_q  <= addr_q + 1'b1;
                            wdata_q <= buf_head_next;
                        end
                    end
                end
                ST_DONE: pending[grant] <= 1'b0;
                default: ;
            endcase
        end
    end

    // completion pulse for the channel that just finished
    always_comb begin
        ch_done = '0;
        if (state == ST_DONE) ch_done[grant] = 1'b1;
    end

    assign ch_desc_ready = ~pending;
    assign busy          = (state != ST_IDLE) || (|pending);
    assign active_ch     = (state == ST_RD || state == ST_WR || state == ST_DONE) ? grant : '0;
    assign mem.mem_req   = req_q;
    assign mem.mem_rw    = rw_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

`ifdef DMA_SCHED_PERF_EN
    // free-running counters of completed writes and of cycles spent waiting on the controller
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_words <= '0;
            perf_stall <= '0;
        end else begin
            if (pop)                    perf_words <= perf_words + 1'b1;
            if (req_q && !mem.mem_ack)  perf_stall <= perf_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// tb/tb_dma_channel_scheduler.sv - scoreboard bench for dma_channel_scheduler
module tb_dma_channel_scheduler;

    localparam int NC = 3;
    localparam int AW = 22;
    localparam int DW = 32;
    localparam int LW = 12;

    typedef struct {
        bit          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [NC-1:0]     valid;
    logic [NC-1:0]     ready;
    logic [NC*AW-1:0]  src_bus;
    logic [NC*AW-1:0]  dst_bus;
    logic [NC*LW-1:0]  len_bus;
    logic [NC-1:0]     ch_done;
    logic              busy;
    logic [1:0]        active_ch;
`ifdef DMA_SCHED_PERF_EN
    logic [31:0]       perf_words;
    logic [31:0]       perf_stall;
`endif

    op_t sb_ops[$];
    int  sb_done[$];
    int  total = 0;
    int  bad   = 0;
    int  ack_delay = 0;

    always #5 clk = ~clk;

    dma_channel_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif ();

    dma_channel_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .ch_desc_valid (valid),
        .ch_desc_ready (ready),
        .ch_src_addr   (src_bus),
        .ch_dst_addr   (dst_bus),
        .ch_len        (len_bus),
        .ch_done       (ch_done),
        .mem           (mif),
        .busy          (busy),
        .active_ch     (active_ch)
`ifdef DMA_SCHED_PERF_EN
        ,
        .perf_words    (perf_words),
        .perf_stall    (perf_stall)
`endif
    );

    function automatic logic [DW-1:0] model(logic [AW-1:0] a);
        return {10'h2B3, a};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // memory responder and scoreboard monitor, acting only at negedges
    initial begin : monitor
        int            wait_cnt;
        int            c;
        op_t           e;
        logic          seen_rw;
        logic [AW-1:0] seen_addr;
        logic [DW-1:0] seen_wdata;
        wait_cnt = 0;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;
        forever begin
            @(negedge clk);
            mif.mem_ack = 1'b0;
            if (|ch_done) begin
                if (sb_done.size() == 0) begin
                    chk("unexpected_done", 64'(ch_done), 64'd0);
                end else begin
                    c = sb_done.pop_front();
                    chk("done_onehot", 64'(ch_done), 64'(1 << c));
                end
            end
            if (rst_n && mif.mem_req) begin
                if (wait_cnt == 0) begin
                    seen_rw    = mif.mem_rw;
                    seen_addr  = mif.mem_addr;
                    seen_wdata = mif.mem_wdata;
                end
                if (wait_cnt >= ack_delay) begin
                    if (ack_delay > 0) begin
                        chk("held_rw_addr", 64'({mif.mem_rw, mif.mem_addr}), 64'({seen_rw, seen_addr}));
                        if (seen_rw) chk("held_wdata", 64'(mif.mem_wdata), 64'(seen_wdata));
                    end
                    if (sb_ops.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_op: got rw=%0d addr=%0h expected no request", mif.mem_rw, mif.mem_addr);
                    end else begin
                        e = sb_ops.pop_front();
                        chk("op_rw_addr", 64'({mif.mem_rw, mif.mem_addr}), 64'({e.rw, e.addr}));
                        if (e.rw) chk("op_wdata", 64'(mif.mem_wdata), 64'(e.data));
                    end
                    mif.mem_ack   = 1'b1;
                    mif.mem_rdata = model(mif.mem_addr);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic set_desc(int ch, logic [AW-1:0] s, logic [AW-1:0] d, logic [LW-1:0] l);
        src_bus[ch*AW +: AW] = s;
        dst_bus[ch*AW +: AW] = d;
        len_bus[ch*LW +: LW] = l;
    endtask

    task automatic fire(logic [NC-1:0] m);
        @(negedge clk);
        valid = m;
        @(negedge clk);
        valid = '0;
    endtask

    task automatic push_burst(logic [AW-1:0] s, logic [AW-1:0] d, int n);
        logic [AW-1:0] a;
        for (int k = 0; k < n; k++) begin
            a = s + AW'(k);
            sb_ops.push_back('{1'b0, a, '0});
        end
        for (int k = 0; k < n; k++) begin
            a = s + AW'(k);
            sb_ops.push_back('{1'b1, d + AW'(k), model(a)});
        end
    endtask

    task automatic wait_idle(string name, int budget);
        int c;
        c = 0;
        repeat (2) @(negedge clk);
        while (busy && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk({name, "_finished"}, 64'(c < budget), 64'd1);
        chk({name, "_ops_left"}, 64'(sb_ops.size()), 64'd0);
        chk({name, "_done_left"}, 64'(sb_done.size()), 64'd0);
    endtask

    task automatic wait_req(string name, int budget);
        int c;
        c = 0;
        while (!mif.mem_req && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk({name, "_req_seen"}, 64'(c < budget), 64'd1);
    endtask

    task automatic do_reset();
        enable = 1'b1;
        valid  = '0;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        sb_ops.delete();
        sb_done.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_idle_outputs(string name);
        chk({name, "_ready"},  64'(ready), 64'h7);
        chk({name, "_busy"},   64'(busy), 64'd0);
        chk({name, "_req"},    64'(mif.mem_req), 64'd0);
        chk({name, "_rw"},     64'(mif.mem_rw), 64'd0);
        chk({name, "_addr"},   64'(mif.mem_addr), 64'd0);
        chk({name, "_wdata"},  64'(mif.mem_wdata), 64'd0);
        chk({name, "_active"}, 64'(active_ch), 64'd0);
        chk({name, "_done"},   64'(ch_done), 64'd0);
    endtask

    initial begin : stimulus
        int c;
        rst_n   = 1'b0;
        enable  = 1'b1;
        valid   = '0;
        src_bus = '0;
        dst_bus = '0;
        len_bus = '0;

        do_reset();
        chk_idle_outputs("reset");

        // single short copy
        set_desc(0, 22'h100, 22'h200, 12'd3);
        push_burst(22'h100, 22'h200, 3);
        sb_done.push_back(0);
        fire(3'b001);
        chk("t1_ready_low", 64'(ready[0]), 64'd0);
        wait_idle("t1", 200);
        chk("t1_ready_back", 64'(ready), 64'h7);

        // two channels accepted together, interleaved at burst boundaries
        do_reset();
        set_desc(0, 22'h000, 22'h400, 12'd20);
        set_desc(1, 22'h800, 22'hC00, 12'd5);
        push_burst(22'h000, 22'h400, 8);
        push_burst(22'h800, 22'hC00, 5);
        sb_done.push_back(1);
        push_burst(22'h008, 22'h408, 8);
        push_burst(22'h010, 22'h410, 4);
        sb_done.push_back(0);
        fire(3'b011);
        wait_idle("t2", 1000);

        // zero-length descriptor: completion with no memory traffic
        do_reset();
        set_desc(2, 22'h050, 22'h060, 12'd0);
        sb_done.push_back(2);
        fire(3'b100);
        wait_idle("t3", 100);

        // source address wraps at the top of the address space
        do_reset();
        set_desc(0, 22'h3FFFFE, 22'h001000, 12'd4);
        sb_ops.push_back('{1'b0, 22'h3FFFFE, '0});
        sb_ops.push_back('{1'b0, 22'h3FFFFF, '0});
        sb_ops.push_back('{1'b0, 22'h000000, '0});
        sb_ops.push_back('{1'b0, 22'h000001, '0});
        sb_ops.push_back('{1'b1, 22'h001000, model(22'h3FFFFE)});
        sb_ops.push_back('{1'b1, 22'h001001, model(22'h3FFFFF)});
        sb_ops.push_back('{1'b1, 22'h001002, model(22'h000000)});
        sb_ops.push_back('{1'b1, 22'h001003, model(22'h000001)});
        sb_done.push_back(0);
        fire(3'b001);
        wait_idle("t4", 200);

        // enable dropped mid-burst: burst drains, then pause until re-enabled
        do_reset();
        set_desc(0, 22'h300, 22'h500, 12'd12);
        push_burst(22'h300, 22'h500, 8);
        push_burst(22'h308, 22'h508, 4);
        sb_done.push_back(0);
        fire(3'b001);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        c = 0;
        while (sb_ops.size() > 8 && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("t5_first_burst_done", 64'(c < 300), 64'd1);
        repeat (20) @(negedge clk);
        chk("t5_paused_req", 64'(mif.mem_req), 64'd0);
        chk("t5_paused_ops_left", 64'(sb_ops.size()), 64'd8);
        chk("t5_paused_busy", 64'(busy), 64'd1);
        enable = 1'b1;
        wait_idle("t5", 300);

        // slow controller, then reset while a read is outstanding
        do_reset();
        ack_delay = 5;
        set_desc(1, 22'h040, 22'h080, 12'd3);
        push_burst(22'h040, 22'h080, 3);
        sb_done.push_back(1);
        fire(3'b010);
        wait_req("t6a", 50);
        chk("t6_active_ch", 64'(active_ch), 64'd1);
        chk("t6_ready1_low", 64'(ready), 64'h5);
        wait_idle("t6a", 500);
        set_desc(1, 22'h700, 22'h900, 12'd4);
        push_burst(22'h700, 22'h900, 4);
        fire(3'b010);
        wait_req("t6b", 50);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_req_drop", 64'(mif.mem_req), 64'd0);
        sb_ops.delete();
        sb_done.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk_idle_outputs("t6_after_reset");
        ack_delay = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
